// File: rtl/shift_register_universal_param_pkg.sv
// Shared types for the universal shift register: per-bit operation select and burst FSM states.
package shift_register_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DONE
  } state_t;

endpackage

// File: rtl/shift_register_universal_param_if.sv
// Control/data bundle between the shift register and its user (serial front end or datapath).
interface shift_register_universal_param_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic             rotate;
  logic             serial_in_msb;
  logic             serial_in_lsb;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [CNT_W-1:0] shift_count;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_lsb;
  logic             serial_out_msb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, rotate, serial_in_msb, serial_in_lsb, parallel_in, start, shift_count,
    input  parallel_out, serial_out_lsb, serial_out_msb, busy, done
  );

  modport slave (
    input  en, mode, rotate, serial_in_msb, serial_in_lsb, parallel_in, start, shift_count,
    output parallel_out, serial_out_lsb, serial_out_msb, busy, done
  );

endinterface

// File: rtl/shift_register_universal_param_cell.sv
// One register bit: 4:1 select between hold, right neighbour, left neighbour and parallel data.
module shift_register_universal_cell
  import shift_register_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  mode_t sel,
  input  logic  right_nb,
  input  logic  left_nb,
  input  logic  par,
  output logic  q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case (sel)
        MODE_HOLD: q <= q;
        MODE_SHR:  q <= right_nb;
        MODE_SHL:  q <= left_nb;
        MODE_LOAD: q <= par;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_register_universal_param.sv
// Universal shift register: single-step shift/rotate/load plus a counted burst engine.
module shift_register_universal_param
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  shift_register_universal_param_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] right_v;
  logic [WIDTH-1:0] left_v;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_t            dir_q, dir_d;
  logic             rot_q, rot_d;

  mode_t            req_mode;
  mode_t            eff_mode;
  logic             eff_rot;
  logic             in_msb;
  logic             in_lsb;
  logic [CNT_W-1:0] cnt_sat;

  assign req_mode = mode_t'(bus.mode);
  assign cnt_sat  = (bus.shift_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.shift_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= MODE_HOLD;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  // The FSM resolves one effective per-bit operation; a burst start forces HOLD on its own edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    rot_d    = rot_q;
    eff_mode = MODE_HOLD;
    eff_rot  = bus.rotate;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && (req_mode == MODE_SHR || req_mode == MODE_SHL)) begin
          dir_d   = req_mode;
          rot_d   = bus.rotate;
          cnt_d   = cnt_sat;
          state_d = (cnt_sat == '0) ? ST_DONE : ST_BURST;
        end else if (bus.en) begin
          eff_mode = req_mode;
        end
      end
      ST_BURST: begin
        eff_mode = dir_q;
        eff_rot  = rot_q;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_msb  = eff_rot ? q[0]       : bus.serial_in_msb;
  assign in_lsb  = eff_rot ? q[WIDTH-1] : bus.serial_in_lsb;
  assign right_v = {in_msb, q[WIDTH-1:1]};
  assign left_v  = {q[WIDTH-2:0], in_lsb};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_register_universal_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (eff_mode),
      .right_nb (right_v[i]),
      .left_nb  (left_v[i]),
      .par      (bus.parallel_in[i]),
      .q        (q[i])
    );
  end

  assign bus.parallel_out   = q;
  assign bus.serial_out_lsb = q[0];
  assign bus.serial_out_msb = q[WIDTH-1];
  assign bus.busy           = (state_q == ST_BURST);
  assign bus.done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_register_universal_param.sv
// Bench for the universal shift register: directed table, reset corners, WIDTH=8 rotate, random vs model.
module tb_shift_register_universal_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_register_universal_param_if #(.WIDTH(4)) bus4 ();
  shift_register_universal_param_if #(.WIDTH(8)) bus8 ();

  shift_register_universal_param #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  shift_register_universal_param #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is a schedule of pending edges (N shifts then a done slot).
  typedef struct { bit is_done; bit left; bit rot; } op_t;
  op_t      sched[$];
  int       m_q;

  function automatic int shift4(int v, bit left, bit rot, bit smsb, bit slsb);
    int inb;
    if (!left) begin
      inb = rot ? (v % 2) : int'(smsb);
      return (v / 2) + inb * 8;
    end
    inb = rot ? (v / 8) : int'(slsb);
    return ((v * 2) % 16) + inb;
  endfunction

  task automatic model_reset();
    sched.delete();
    m_q = 0;
  endtask

  task automatic model_edge();
    op_t op;
    int  n;
    if (sched.size() > 0) begin
      op = sched.pop_front();
      if (!op.is_done) m_q = shift4(m_q, op.left, op.rot, bus4.serial_in_msb, bus4.serial_in_lsb);
    end else if (bus4.start && (bus4.mode == 2'd1 || bus4.mode == 2'd2)) begin
      n = (int'(bus4.shift_count) > 4) ? 4 : int'(bus4.shift_count);
      for (int i = 0; i < n; i++) sched.push_back('{1'b0, bus4.mode == 2'd2, bus4.rotate});
      sched.push_back('{1'b1, 1'b0, 1'b0});
    end else if (bus4.en) begin
      case (bus4.mode)
        2'd1: m_q = shift4(m_q, 1'b0, bus4.rotate, bus4.serial_in_msb, bus4.serial_in_lsb);
        2'd2: m_q = shift4(m_q, 1'b1, bus4.rotate, bus4.serial_in_msb, bus4.serial_in_lsb);
        2'd3: m_q = int'(bus4.parallel_in);
        default: ;
      endcase
    end
  endtask

  function automatic bit m_busy();
    return sched.size() > 0 && !sched[0].is_done;
  endfunction

  function automatic bit m_done();
    return sched.size() > 0 && sched[0].is_done;
  endfunction

  task automatic cycle4(input logic en, input logic [1:0] mode, input logic rot, input logic smsb,
                        input logic slsb, input logic [3:0] pin, input logic start, input logic [2:0] cnt);
    bus4.en = en; bus4.mode = mode; bus4.rotate = rot;
    bus4.serial_in_msb = smsb; bus4.serial_in_lsb = slsb;
    bus4.parallel_in = pin; bus4.start = start; bus4.shift_count = cnt;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic en; logic [1:0] mode; logic rot; logic smsb; logic slsb;
    logic [3:0] pin; logic start; logic [2:0] cnt;
    logic [3:0] exp_q; logic exp_busy; logic exp_done;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic [1:0] mode, logic rot, logic smsb, logic slsb,
                              logic [3:0] pin, logic start, logic [2:0] cnt,
                              logic [3:0] eq, logic eb, logic ed);
    vec_t v;
    v.en = en; v.mode = mode; v.rot = rot; v.smsb = smsb; v.slsb = slsb;
    v.pin = pin; v.start = start; v.cnt = cnt;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    int busy_cnt;
    bit done_seen;

    model_reset();
    bus4.en = 0; bus4.mode = 0; bus4.rotate = 0; bus4.serial_in_msb = 0; bus4.serial_in_lsb = 0;
    bus4.parallel_in = '0; bus4.start = 0; bus4.shift_count = '0;
    bus8.en = 0; bus8.mode = 0; bus8.rotate = 0; bus8.serial_in_msb = 0; bus8.serial_in_lsb = 0;
    bus8.parallel_in = '0; bus8.start = 0; bus8.shift_count = '0;

    #2;
    chk("reset_q", 64'(bus4.parallel_out), 0);
    chk("reset_busy", 64'(bus4.busy), 0);
    chk("reset_done", 64'(bus4.done), 0);
    chk("reset_sol", 64'(bus4.serial_out_lsb), 0);
    chk("reset_som", 64'(bus4.serial_out_msb), 0);
    chk("reset_q8", 64'(bus8.parallel_out), 0);
    #10 rst_n = 1'b1;

    //             en mode  rot smsb slsb pin     st cnt  exp_q    busy done
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 4'b1001, 0, 0, 4'b1001, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 1, 0, 4'b0000, 0, 0, 4'b1100, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 1, 0, 4'b0000, 0, 0, 4'b1110, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 4'b1000, 0, 0, 4'b1000, 0, 0));
    vecs.push_back(mk(1, 2'd2, 1, 0, 0, 4'b0000, 0, 0, 4'b0001, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 4'b0110, 0, 0, 4'b0110, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 0, 0, 4'b0000, 1, 3, 4'b0110, 1, 0));
    vecs.push_back(mk(1, 2'd3, 1, 1, 0, 4'b1111, 0, 0, 4'b1100, 1, 0));
    vecs.push_back(mk(1, 2'd0, 0, 1, 0, 4'b1111, 0, 0, 4'b1000, 1, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 4'b1111, 0, 0, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 4'b1101, 0, 0, 4'b1101, 0, 0));
    vecs.push_back(mk(0, 2'd1, 1, 0, 0, 4'b0000, 1, 4, 4'b1101, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1110, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b0111, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1011, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1101, 0, 1));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1101, 0, 0));
    vecs.push_back(mk(0, 2'd1, 0, 1, 0, 4'b0000, 1, 0, 4'b1101, 0, 1));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1101, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 4'b0101, 1, 2, 4'b0101, 0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b0101, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 0, 1, 4'b0000, 1, 2, 4'b0101, 1, 0));
    vecs.push_back(mk(0, 2'd2, 0, 0, 1, 4'b0000, 1, 2, 4'b1011, 1, 0));
    vecs.push_back(mk(0, 2'd2, 0, 0, 1, 4'b0000, 1, 2, 4'b0111, 0, 1));
    vecs.push_back(mk(0, 2'd2, 0, 0, 1, 4'b0000, 1, 2, 4'b0111, 0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b0111, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 0, 0, 4'b1001, 0, 0, 4'b1001, 0, 0));
    vecs.push_back(mk(0, 2'd2, 1, 0, 0, 4'b0000, 1, 7, 4'b1001, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b0011, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b0110, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1100, 1, 0));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1001, 0, 1));
    vecs.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 0, 0, 4'b1001, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle4(vecs[i].en, vecs[i].mode, vecs[i].rot, vecs[i].smsb, vecs[i].slsb,
             vecs[i].pin, vecs[i].start, vecs[i].cnt);
      chk($sformatf("vec%0d_q", i), 64'(bus4.parallel_out), 64'(vecs[i].exp_q));
      chk($sformatf("vec%0d_busy", i), 64'(bus4.busy), 64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i), 64'(bus4.done), 64'(vecs[i].exp_done));
      chk($sformatf("vec%0d_sol", i), 64'(bus4.serial_out_lsb), 64'(vecs[i].exp_q[0]));
      chk($sformatf("vec%0d_som", i), 64'(bus4.serial_out_msb), 64'(vecs[i].exp_q[3]));
    end

    // Asynchronous reset between edges after a load
    cycle4(1, 2'd3, 0, 0, 0, 4'b1011, 0, 0);
    chk("pre_reset_q", 64'(bus4.parallel_out), 64'hB);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_q", 64'(bus4.parallel_out), 0);
    chk("async_rst_busy", 64'(bus4.busy), 0);
    chk("async_rst_done", 64'(bus4.done), 0);
    model_reset();
    rst_n = 1'b1;

    // Reset in the middle of a burst: abort, clear, no done pulse afterwards
    cycle4(1, 2'd3, 0, 0, 0, 4'b0111, 0, 0);
    cycle4(0, 2'd1, 0, 1, 0, 4'b0000, 1, 4);
    cycle4(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0);
    chk("midburst_busy", 64'(bus4.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midburst_rst_q", 64'(bus4.parallel_out), 0);
    chk("midburst_rst_busy", 64'(bus4.busy), 0);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle4(0, 2'd0, 0, 1, 1, 4'b0000, 0, 0);
      chk("midburst_no_done", 64'(bus4.done), 0);
      chk("midburst_hold_q", 64'(bus4.parallel_out), 0);
    end

    // WIDTH=8 full-width rotate burst
    bus8.en = 1; bus8.mode = 2'd3; bus8.parallel_in = 8'hB5;
    @(posedge clk); #1;
    chk("w8_load", 64'(bus8.parallel_out), 64'hB5);
    bus8.en = 0; bus8.mode = 2'd1; bus8.rotate = 1; bus8.start = 1; bus8.shift_count = 4'd8;
    bus8.serial_in_msb = 0;
    @(posedge clk); #1;
    bus8.start = 0; bus8.mode = 2'd0; bus8.rotate = 0;
    busy_cnt = 0;
    done_seen = 0;
    for (int i = 0; i < 12 && !done_seen; i++) begin
      if (bus8.busy) busy_cnt++;
      if (bus8.done) begin
        done_seen = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("w8_done_seen", 64'(done_seen), 1);
    chk("w8_busy_cycles", 64'(busy_cnt), 8);
    chk("w8_rotate_q", 64'(bus8.parallel_out), 64'hB5);
    @(posedge clk); #1;
    chk("w8_done_pulse", 64'(bus8.done), 0);

    // Randomised traffic against the schedule model
    for (int i = 0; i < 400; i++) begin
      cycle4(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)));
      chk("rand_q", 64'(bus4.parallel_out), 64'(m_q));
      chk("rand_busy", 64'(bus4.busy), 64'(m_busy()));
      chk("rand_done", 64'(bus4.done), 64'(m_done()));
      chk("rand_sol", 64'(bus4.serial_out_lsb), 64'(m_q % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
